// File: rtl/ram.sv
// Byte-addressable little-endian data memory: sized stores on clk, combinational word read.
// Optional RAM_MISALIGN_CHK_EN adds a misaligned flag and suppresses misaligned stores.
module ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   input  logic [1:0]  mem_sz,
   output logic [31:0] data_o
`ifdef RAM_MISALIGN_CHK_EN
   ,
   output logic        misaligned
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] idx [4];
   logic [3:0]            byte_en;
   logic                  store_ok;

   // Byte lanes A..A+3 wrap modulo depth through the natural index width.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         idx[k] = addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
      end
   end

   always_comb begin
      byte_en = 4'b0000;
      case (mem_sz)
         2'd0:    byte_en = 4'b0001;
         2'd1:    byte_en = 4'b0011;
         2'd2:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

`ifdef RAM_MISALIGN_CHK_EN
   assign misaligned = !reset &&
                       ((mem_sz == 2'd1 && addr[0]) ||
                        (mem_sz == 2'd2 && addr[1:0] != 2'b00));
   assign store_ok   = !misaligned;
`else
   assign store_ok   = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (store_ok) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_en[k]) begin
               mem[idx[k]] <= data_i[8*k +: 8];
            end
         end
      end
   end

   assign data_o = reset ? 32'h0000_0000
                         : {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed cases plus randomized stores against a byte-array model.
module tb_ram;

   localparam int AW    = 10;
   localparam int DEPTH = 2 ** AW;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [1:0]  mem_sz;
   logic [31:0] data_o;
`ifdef RAM_MISALIGN_CHK_EN
   logic        misaligned;
`endif

   int vectors;
   int errors;

   logic [7:0] model [DEPTH];

   ram #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .data_i     (data_i),
      .mem_sz     (mem_sz),
      .data_o     (data_o)
`ifdef RAM_MISALIGN_CHK_EN
      ,
      .misaligned (misaligned)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic model_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef RAM_MISALIGN_CHK_EN
      return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      int base;
      logic [31:0] w;
      base = int'(a % DEPTH);
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
         w = w | (32'(model[(base + k) % DEPTH]) << (8 * k));
      end
      return w;
   endfunction

   task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int n;
      int base;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      if (model_misaligned(a, sz)) n = 0;
      base = int'(a % DEPTH);
      for (int k = 0; k < n; k++) begin
         model[(base + k) % DEPTH] = 8'((d >> (8 * k)) & 32'hFF);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      @(negedge clk);
      addr   = a;
      data_i = d;
      mem_sz = sz;
      @(posedge clk);
      #1;
      model_wr(a, d, sz);
      mem_sz = 2'd3;
   endtask

   task automatic look(input logic [31:0] a);
      addr = a;
      #1;
   endtask

   task automatic test_reset();
      do_store(32'h40, 32'h5555AAAA, 2'd2);
      @(negedge clk);
      #2;
      addr   = 32'h40;
      data_i = 32'hFFFFFFFF;
      mem_sz = 2'd2;
      reset  = 1'b1;
      #1;
      model_clear();
      vectors++;
      if (data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_immediate got %h want %h", data_o, 32'h0);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         addr = (i == 0) ? 32'h0 : (i == 1) ? 32'h3FF : 32'h40;
         #1;
         vectors++;
         if (data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_held addr %h got %h want %h", addr, data_o, 32'h0);
         end
      end
      @(negedge clk);
      mem_sz = 2'd3;
      reset  = 1'b0;
      @(posedge clk);
      #1;
      look(32'h40);
      vectors++;
      if (data_o !== model_rd(32'h40) || data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_no_write got %h want %h", data_o, 32'h0);
      end
   endtask

   task automatic test_word();
      do_store(32'h10, 32'hDEADBEEF, 2'd2);
      look(32'h10);
      vectors++;
      if (data_o !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_load got %h want %h", data_o, 32'hDEADBEEF);
      end
      look(32'h11);
      vectors++;
      if (data_o !== 32'h00DEADBE) begin
         errors++;
         $display("FAIL word_unaligned_read got %h want %h", data_o, 32'h00DEADBE);
      end
   endtask

   task automatic test_halfword();
      do_store(32'h22, 32'h12345678, 2'd1);
      look(32'h22);
      vectors++;
      if (data_o !== 32'h00005678) begin
         errors++;
         $display("FAIL half_store got %h want %h", data_o, 32'h00005678);
      end
      do_store(32'h20, 32'h0, 2'd1);
      look(32'h20);
      vectors++;
      if (data_o !== 32'h56780000) begin
         errors++;
         $display("FAIL half_zero got %h want %h", data_o, 32'h56780000);
      end
   endtask

   task automatic test_byte_nostore();
      do_store(32'h31, 32'h000000AB, 2'd0);
      look(32'h30);
      vectors++;
      if (data_o !== 32'h0000AB00) begin
         errors++;
         $display("FAIL byte_store got %h want %h", data_o, 32'h0000AB00);
      end
      do_store(32'h31, 32'h000000FF, 2'd3);
      look(32'h30);
      vectors++;
      if (data_o !== 32'h0000AB00) begin
         errors++;
         $display("FAIL no_store got %h want %h", data_o, 32'h0000AB00);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
`ifdef RAM_MISALIGN_CHK_EN
      exp_lo = 32'h0;
      exp_hi = 32'h0;
`else
      exp_lo = 32'h0000A1B2;
      exp_hi = 32'hA1B2C3D4;
`endif
      do_store(32'h3FE, 32'hA1B2C3D4, 2'd2);
      look(32'h000);
      vectors++;
      if (data_o !== exp_lo) begin
         errors++;
         $display("FAIL wrap_low got %h want %h", data_o, exp_lo);
      end
      look(32'hFFFF_F3FE);
      vectors++;
      if (data_o !== exp_hi) begin
         errors++;
         $display("FAIL alias_high got %h want %h", data_o, exp_hi);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] r;
      logic [1:0]  sz;
      for (int n = 0; n < 100; n++) begin
         a  = $urandom();
         d  = $urandom();
         sz = (n < 50) ? 2'd2 : 2'd1;
`ifdef RAM_MISALIGN_CHK_EN
         @(negedge clk);
         addr   = a;
         mem_sz = sz;
         #1;
         vectors++;
         if (misaligned !== model_misaligned(a, sz)) begin
            errors++;
            $display("FAIL misaligned addr %h sz %0d got %b want %b", a, sz, misaligned, model_misaligned(a, sz));
         end
`endif
         do_store(a, d, sz);
         look(a);
         vectors++;
         if (data_o !== model_rd(a)) begin
            errors++;
            $display("FAIL rand_same addr %h got %h want %h", a, data_o, model_rd(a));
         end
         r = $urandom();
         look(r);
         vectors++;
         if (data_o !== model_rd(r)) begin
            errors++;
            $display("FAIL rand_other addr %h got %h want %h", r, data_o, model_rd(r));
         end
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      reset   = 1'b1;
      addr    = 32'h0;
      data_i  = 32'h0;
      mem_sz  = 2'd3;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_word();
      test_halfword();
      test_byte_nostore();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout vectors %0d", vectors);
      $fatal(1);
   end

endmodule

// File: doc/ram.md
Name: ram

Overview:
- Byte-addressable, little-endian data memory for the RV32I core.
- Stores byte, halfword or word on the rising clock edge.
- Read is combinational and always returns the 32-bit word starting at the addressed byte.
- Sits on the core's load/store path; load sign/zero extension is done outside this block.

Parameters:
- ADDR_WIDTH, 10, number of implemented byte-address bits; depth = 2**ADDR_WIDTH bytes.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address; only addr[ADDR_WIDTH-1:0] used, upper bits ignored.
- data_i  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- mem_sz  input  2  store size: 0 = byte, 1 = halfword, 2 = word, 3 = no store.
- data_o  output  32  combinational read data.

Behaviour:
- Storage: array of 2**ADDR_WIDTH bytes. Effective byte index is A = addr mod depth.
- Reset:
  - reset high asynchronously clears every byte to 0x00; data_o reads 0x00000000 while reset is held.
  - No writes occur while reset is high.
  - Deassertion is synchronised by the normal clk edge; the first write can happen on the first rising edge with reset low.
- Write: on each rising clk edge with reset low:
  - mem_sz=0: mem[A] <= data_i[7:0].
  - mem_sz=1: mem[A] <= data_i[7:0]; mem[A+1] <= data_i[15:8].
  - mem_sz=2: bytes A..A+3 <= data_i[7:0], [15:8], [23:16], [31:24].
  - mem_sz=3: no change.
  - Bytes outside the selected size are untouched.
  - There is no separate write enable; the core drives mem_sz=3 when not storing.
- Read: data_o = {mem[A+3], mem[A+2], mem[A+1], mem[A]}, purely combinational from addr and memory contents, independent of mem_sz.
  - After a write edge, data_o reflects new contents in the same cycle (zero-latency read-after-write visibility once the edge passes).
- Alignment: unaligned accesses are fully supported for both read and write; no trap.
- Wrap-around: byte indices A+1..A+3 are computed modulo depth, so an access at depth-1 wraps to byte 0.
- Simultaneous read/write to the same address: data_o shows old data before the edge and new data after it.

Optional Feature:
- Macro: RAM_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misaligned (1 bit, combinational).
  - misaligned is asserted when mem_sz=1 and addr[0]=1, or mem_sz=2 and addr[1:0]!=0.
  - A store with misaligned asserted is suppressed (memory unchanged).
  - Reads are unaffected.
  - misaligned is 0 during reset.
- Undefined: no misaligned port; unaligned stores are performed as described in Behaviour.

Test Plan:
- Reset: pulse reset high mid-cycle with mem_sz=2, data_i=0xFFFFFFFF -> data_o=0x00000000 immediately and at any addr; no write occurs on edges during reset.
- Word store/load: addr=0x10, data_i=0xDEADBEEF, mem_sz=2, clock edge -> data_o=0xDEADBEEF; addr=0x11 -> data_o=0x00DEADBE.
- Halfword then zero halfword:
  - Step 1: addr=0x22, data_i=0x12345678, mem_sz=1, edge -> data_o at 0x22 = 0x00005678 (after prior reset).
  - Step 2: set addr=0x20, data_i=0, mem_sz=1, edge -> data_o at 0x20 = 0x56780000.
- Byte store and no-store:
  - addr=0x31, data_i=0xAB, mem_sz=0, edge -> data_o at 0x30 = 0x0000AB00.
  - Then mem_sz=3, data_i=0xFF, edge -> unchanged.
- Wrap and upper-bit aliasing (ADDR_WIDTH=10):
  - addr=0x3FE, word 0xA1B2C3D4 -> bytes 0x3FE,0x3FF,0x000,0x001 written; addr=0x000 reads 0x0000A1B2.
  - addr=0xFFFF_F3FE reads 0xA1B2C3D4.
- Random soak: 50 random word stores and 50 halfword stores at random addr against a byte-array reference model -> data_o always matches the model.
